// File: rtl/sram_bist_seq.sv
// SRAM test sequencer: writes a pattern to DEPTH words, reads them back, reports errors.
// Define SRAM_BIST_INV_PASS_EN for a second write/read pass using inverted patterns.
module sram_bist_seq #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 11,
  parameter int DEPTH     = 128,
  parameter int START_VAL = 127,
  parameter int ERR_W     = 8
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        mode_q;
  logic              inv;
  logic [DATA_W-1:0] cur_pat;
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    logic [31:0]       sh;
    p  = '0;
    sh = 32'(a) % 32'(DATA_W);
    case (m)
      2'b00: p = DATA_W'(START_VAL) - DATA_W'(a);
      2'b01: p = DATA_W'(a);
      2'b10: for (int i = 0; i < DATA_W; i++) p[i] = a[0] ^ (i % 2 == 0);
      default: p = DATA_W'(1) << sh;
    endcase
    return p;
  endfunction

  // The same word serves as write data and as the expected read-back value.
  assign cur_pat = pattern(mode_q, addr) ^ {DATA_W{inv}};

`ifndef SRAM_BIST_INV_PASS_EN
  assign inv = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state          <= S_IDLE;
      addr           <= '0;
      mode_q         <= 2'b00;
      err_count      <= '0;
      first_err_addr <= '0;
      cmp_vld        <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
`ifdef SRAM_BIST_INV_PASS_EN
      inv            <= 1'b0;
`endif
    end else begin
      // Align expectation with the SRAM's one-cycle read latency.
      cmp_vld  <= (state == S_READ);
      cmp_exp  <= cur_pat;
      cmp_addr <= addr;
      if (cmp_vld && (mem_rdata != cmp_exp)) begin
        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
        if (err_count == '0) first_err_addr <= cmp_addr;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_WRITE;
            addr           <= '0;
            mode_q         <= mode;
            err_count      <= '0;
            first_err_addr <= '0;
`ifdef SRAM_BIST_INV_PASS_EN
            inv            <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          addr <= addr + ADDR_W'(1);
          if (addr == LAST) begin
            addr  <= '0;
            state <= S_READ;
          end
        end
        S_READ: begin
          addr <= addr + ADDR_W'(1);
          if (addr == LAST) begin
            addr <= '0;
`ifdef SRAM_BIST_INV_PASS_EN
            if (!inv) begin
              inv   <= 1'b1;
              state <= S_WRITE;
            end else begin
              state <= S_DRAIN;
            end
`else
            state <= S_DRAIN;
`endif
          end
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = ((state == S_WRITE) || (state == S_READ)) ? addr : '0;
    mem_wdata = (state == S_WRITE) ? cur_pat : '0;
    mem_we_n  = (state != S_WRITE);
    mem_oe_n  = (state != S_READ);
    busy      = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    done      = (state == S_DONE);
    pass      = (state == S_DONE) && (err_count == '0);
  end

endmodule

// File: tb/tb_sram_bist_seq.sv
// Scoreboard bench for sram_bist_seq: a main instance plus a DEPTH=1, 8-bit instance.
module tb_sram_bist_seq;
  localparam int DW = 16, AW = 11, DEPTH = 128, SV = 127, EW = 4;
  localparam int SDW = 8, SAW = 2;
`ifdef SRAM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int LAT  = 2 * NPASS * DEPTH + 1;
  localparam int SLAT = 2 * NPASS + 1;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int errs; int first; int lat; int e0; } res_t;

  logic CLK, rst, start;
  logic [1:0] mode;
  logic [AW-1:0] mem_addr, first_err_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic mem_we_n, mem_oe_n, busy, done, pass;
  logic [EW-1:0] err_count;

  logic s_start;
  logic [1:0] s_mode;
  logic [SAW-1:0] s_mem_addr, s_first;
  logic [SDW-1:0] s_wdata, s_rdata;
  logic s_we_n, s_oe_n, s_busy, s_done, s_pass;
  logic [7:0] s_err;

  sram_bist_seq #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .START_VAL(SV), .ERR_W(EW)) u_dut (
    .CLK(CLK), .rst(rst), .start(start), .mode(mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr));

  sram_bist_seq #(.DATA_W(SDW), .ADDR_W(SAW), .DEPTH(1), .START_VAL(SV), .ERR_W(8)) u_small (
    .CLK(CLK), .rst(rst), .start(s_start), .mode(s_mode),
    .mem_addr(s_mem_addr), .mem_wdata(s_wdata), .mem_we_n(s_we_n), .mem_oe_n(s_oe_n),
    .mem_rdata(s_rdata), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_err_addr(s_first));

  int checks = 0, errors = 0, cyc = 0, fault = 0;
  wr_t wq[$], swq[$];
  res_t rq[$], srq[$];
  logic [DW-1:0] mem [2**AW];
  logic [SDW-1:0] smem [2**SAW];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pat(input int m, input int a, input int dw);
    int mask;
    mask = (1 << dw) - 1;
    case (m)
      0: return (SV - a) & mask;
      1: return a & mask;
      2: return ((a % 2) != 0 ? 32'hAAAA : 32'h5555) & mask;
      default: return (1 << (a % dw)) & mask;
    endcase
  endfunction

  // fault 1: address 5 bit 0 stuck at 1; fault 2: every location has bit 0 flipped.
  function automatic int faulty(input int a, input int d);
    if (fault == 1 && a == 5) return d | 1;
    if (fault == 2) return d ^ 1;
    return d;
  endfunction

  always @(posedge CLK) begin
    if (!mem_we_n) mem[mem_addr] <= DW'(faulty(int'(mem_addr), int'(mem_wdata)));
    if (!mem_oe_n) mem_rdata <= mem[mem_addr];
    if (!s_we_n) smem[s_mem_addr] <= s_wdata;
    if (!s_oe_n) s_rdata <= smem[s_mem_addr];
  end

  task automatic push_run(input int m, input int e0);
    res_t r;
    int d;
    r.errs = 0; r.first = 0; r.e0 = e0; r.lat = LAT;
    for (int p = 0; p < NPASS; p++)
      for (int a = 0; a < DEPTH; a++) begin
        d = pat(m, a, DW) ^ (p != 0 ? 32'hFFFF : 0);
        wq.push_back('{addr: a, data: d});
        if (faulty(a, d) != d) begin
          if (r.errs == 0) r.first = a;
          if (r.errs < (1 << EW) - 1) r.errs++;
        end
      end
    rq.push_back(r);
  endtask

  task automatic run(input int m, input int f);
    fault = f;
    push_run(m, cyc + 1);
    mode = 2'(m);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    mode = 2'($urandom);
  endtask

  task automatic wait_done(input bit sm);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(sm ? s_done : done) && n < 3000);
    chk(sm ? "small_done_seen" : "done_seen", int'(sm ? s_done : done), 1);
  endtask

  task automatic reset_check(input string nm);
    rst = 1'b0;
    @(negedge CLK);
    chk({nm, "_addr"}, int'(mem_addr), 0);
    chk({nm, "_wdata"}, int'(mem_wdata), 0);
    chk({nm, "_we_n"}, int'(mem_we_n), 1);
    chk({nm, "_oe_n"}, int'(mem_oe_n), 1);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_pass"}, int'(pass), 0);
    chk({nm, "_err"}, int'(err_count), 0);
    chk({nm, "_first"}, int'(first_err_addr), 0);
    chk({nm, "_small_done"}, int'(s_done), 0);
    rst = 1'b1;
    @(negedge CLK);
  endtask

  wr_t mw, sw;
  res_t mr, sr;
  logic done_q = 1'b0, s_done_q = 1'b0;

  always @(negedge CLK) begin
    if (rst && !mem_we_n) begin
      chk("wr_oe_n", int'(mem_oe_n), 1);
      if (wq.size() == 0) chk("unexpected_write_addr", int'(mem_addr), -1);
      else begin
        mw = wq.pop_front();
        chk("wr_addr", int'(mem_addr), mw.addr);
        chk("wr_data", int'(mem_wdata), mw.data);
      end
    end
    if (rst && done && !done_q) begin
      if (rq.size() == 0) chk("unexpected_done", int'(done), 0);
      else begin
        mr = rq.pop_front();
        chk("done_latency", cyc - mr.e0, mr.lat);
        chk("err_count", int'(err_count), mr.errs);
        chk("pass", int'(pass), int'(mr.errs == 0));
        if (mr.errs != 0) chk("first_err_addr", int'(first_err_addr), mr.first);
      end
    end
    done_q = done;
  end

  always @(negedge CLK) begin
    if (rst && !s_we_n) begin
      if (swq.size() == 0) chk("small_unexpected_write", int'(s_mem_addr), -1);
      else begin
        sw = swq.pop_front();
        chk("small_wr_addr", int'(s_mem_addr), sw.addr);
        chk("small_wr_data", int'(s_wdata), sw.data);
      end
    end
    if (rst && s_done && !s_done_q) begin
      if (srq.size() == 0) chk("small_unexpected_done", int'(s_done), 0);
      else begin
        sr = srq.pop_front();
        chk("small_done_latency", cyc - sr.e0, sr.lat);
        chk("small_err_count", int'(s_err), 0);
        chk("small_pass", int'(s_pass), 1);
      end
    end
    s_done_q = s_done;
  end

  task automatic run_small(input int m);
    for (int p = 0; p < NPASS; p++)
      swq.push_back('{addr: 0, data: pat(m, 0, SDW) ^ (p != 0 ? 32'hFF : 0)});
    srq.push_back('{errs: 0, first: 0, lat: SLAT, e0: cyc + 1});
    s_mode = 2'(m);
    s_start = 1'b1;
    @(negedge CLK);
    s_start = 1'b0;
    s_mode = ~s_mode;
    wait_done(1'b1);
  endtask

  initial begin
    int n, e0, m;
    rst = 1'b0; start = 1'b0; mode = 2'b00; s_start = 1'b0; s_mode = 2'b00;
    repeat (2) @(negedge CLK);
    reset_check("por");

    run(0, 0); wait_done(1'b0);
    run(2, 0); wait_done(1'b0);
    run(1, 1); wait_done(1'b0);
    run(0, 1); wait_done(1'b0);
    run(1, 2); wait_done(1'b0);
    reset_check("rst_after_fail");

    // Abort during WRITE at address 40; no write at a>=41 may follow.
    run(3, 0);
    n = 0;
    while (!(!mem_we_n && mem_addr == AW'(40)) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_reached_addr40", int'(mem_addr), 40);
    #1;
    rst = 1'b0;
    wq.delete();
    rq.delete();
    @(negedge CLK);
    rst = 1'b1;
    chk("abort_we_n", int'(mem_we_n), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (3) @(negedge CLK);
    chk("abort_idle_busy", int'(busy), 0);
    run(0, 0); wait_done(1'b0);

    // start held across a whole run restarts on the edge after done.
    m = int'($urandom_range(3, 0));
    fault = int'($urandom_range(2, 0));
    e0 = cyc + 1;
    push_run(m, e0);
    push_run(m, e0 + LAT + 1);
    mode = 2'(m);
    start = 1'b1;
    wait_done(1'b0);
    @(negedge CLK);
    chk("held_restart_done_low", int'(done), 0);
    chk("held_restart_busy", int'(busy), 1);
    start = 1'b0;
    wait_done(1'b0);

    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
      wait_done(1'b0);
      repeat ($urandom_range(3, 0)) @(negedge CLK);
    end

    for (int k = 0; k < 4; k++) run_small(k);
    run_small(int'($urandom_range(3, 0)));

    repeat (3) @(negedge CLK);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("small_wq_drained", swq.size(), 0);
    chk("small_rq_drained", srq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
